// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges a CPU MAR/MDR pair to a single-request memory port.
//
// A registered three-state FSM (IDLE -> ACCESS -> DONE -> IDLE). Every output
// comes from a register.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   req, we          CPU access request (sampled in IDLE) and type (1 = write)
//   mar, mdr_in      address and write data from the CPU
//   mdr_out          read data for the CPU MDR
//   mdr_load         one-cycle strobe: CPU loads mdr_out
//   busy             access in progress (ACCESS and DONE)
//   done, err        one-cycle completion strobe; err marks an aborted access
//   mem_en, mem_we   memory request (held until mem_ready) and write enable
//   mem_addr         memory address
//   mem_wdata        memory write data
//   mem_rdata        memory read data, valid with mem_ready
//   mem_ready        memory accepts/completes the access this cycle
//
// Build option: define MEM_BUS_TIMEOUT_EN to abort an ACCESS that has seen no
// mem_ready for TIMEOUT cycles. Without it, err is tied to 0 and TIMEOUT is
// only range-checked.
module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mdr_out,
    output logic        mdr_load,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_bus_ctrl: TIMEOUT must be in 1..255");
    end

    state_t      state, next_state;
    logic [15:0] next_mdr_out;
    logic        next_mdr_load;
    logic        next_busy;
    logic        next_done;
    logic        next_err;
    logic        next_mem_en;
    logic        next_mem_we;
    logic [15:0] next_mem_addr;
    logic [15:0] next_mem_wdata;

`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0]  cnt, next_cnt;
    logic        err_q;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        next_state     = state;
        next_mdr_out   = mdr_out;
        next_mdr_load  = 1'b0;
        next_busy      = busy;
        next_done      = 1'b0;
        next_err       = 1'b0;
        next_mem_en    = mem_en;
        next_mem_we    = mem_we;
        next_mem_addr  = mem_addr;
        next_mem_wdata = mem_wdata;
`ifdef MEM_BUS_TIMEOUT_EN
        next_cnt       = cnt;
`endif
        case (state)
            IDLE: begin
                next_busy = 1'b0;
                if (req) begin
                    next_mem_addr  = mar;
                    next_mem_wdata = mdr_in;
                    next_mem_we    = we;
                    next_mem_en    = 1'b1;
                    next_busy      = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
                    next_cnt       = '0;
`endif
                    next_state     = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    next_mem_en   = 1'b0;
                    next_done     = 1'b1;
                    next_mdr_load = ~mem_we;
                    if (!mem_we) next_mdr_out = mem_rdata;
                    next_state    = DONE;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (cnt == TIMEOUT_LAST) begin
                    // Abort: strobe done with err, keep mdr_out untouched.
                    next_mem_en = 1'b0;
                    next_done   = 1'b1;
                    next_err    = 1'b1;
                    next_state  = DONE;
                end else begin
                    next_cnt = cnt + 8'd1;
                end
`endif
            end
            DONE: begin
                next_busy  = 1'b0;
                next_state = IDLE;
            end
            default: begin
                next_busy   = 1'b0;
                next_mem_en = 1'b0;
                next_state  = IDLE;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr_out   <= '0;
            mdr_load  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mdr_out   <= next_mdr_out;
            mdr_load  <= next_mdr_load;
            busy      <= next_busy;
            done      <= next_done;
            mem_en    <= next_mem_en;
            mem_we    <= next_mem_we;
            mem_addr  <= next_mem_addr;
            mem_wdata <= next_mem_wdata;
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            cnt   <= next_cnt;
            err_q <= next_err;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;

    logic unused_err;
    assign unused_err = next_err;
`endif

endmodule
